// File: rtl/my8_bus_arbiter.sv
// my8_bus_arbiter: two-requester arbiter and sequencer for the my8_mem multiplexed address/data bus.
// Define MY8_ARB_FIXED_PRIO_EN to make the core always win ties (default build is round-robin).
module my8_bus_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              req0,
    input  logic              rW0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              rW1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_do,
    output logic              mem_rW,
    output logic [ADDR_W-1:0] mem_ad_out,
    output logic              mem_ad_oe,
    input  logic [DATA_W-1:0] mem_ad_in
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              sel;
    logic              sel_nx;
    logic              rw_q;
    logic              rw_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_nx;
    logic              last_grant;
    logic              last_grant_nx;
    logic              pick;

    logic              ack0_nx;
    logic              ack1_nx;
    logic              busy_nx;
    logic              mem_do_nx;
    logic              mem_rW_nx;
    logic              mem_ad_oe_nx;
    logic [ADDR_W-1:0] mem_ad_out_nx;
    logic [DATA_W-1:0] rdata_nx;

    // Winner if a grant happens this cycle; ties go to whoever was not served last.
    always_comb begin
        pick = req1 & ~req0;
        if (req0 && req1) begin
`ifdef MY8_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_grant;
`endif
        end
    end

    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        rw_nx         = rw_q;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        last_grant_nx = last_grant;
        rdata_nx      = rdata;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx      = ADDR;
                    sel_nx        = pick;
                    rw_nx         = pick ? rW1 : rW0;
                    addr_nx       = pick ? addr1 : addr0;
                    wdata_nx      = pick ? wdata1 : wdata0;
                    last_grant_nx = pick;
                end
            end
            ADDR: state_nx = DATA;
            DATA: begin
                state_nx = ACK;
                if (rw_q) begin
                    rdata_nx = mem_ad_in;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        ack0_nx       = (state_nx == ACK) && !sel_nx;
        ack1_nx       = (state_nx == ACK) && sel_nx;
        busy_nx       = (state_nx != IDLE);
        mem_do_nx     = (state_nx == ADDR) || (state_nx == DATA);
        mem_rW_nx     = mem_do_nx ? rw_nx : 1'b1;
        mem_ad_oe_nx  = (state_nx == ADDR) || ((state_nx == DATA) && !rw_nx);
        mem_ad_out_nx = '0;
        if (state_nx == ADDR) begin
            mem_ad_out_nx = addr_nx;
        end else if ((state_nx == DATA) && !rw_nx) begin
            mem_ad_out_nx = wdata_nx;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            mem_do     <= 1'b0;
            mem_rW     <= 1'b1;
            mem_ad_oe  <= 1'b0;
            mem_ad_out <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            rw_q       <= rw_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            last_grant <= last_grant_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            busy       <= busy_nx;
            mem_do     <= mem_do_nx;
            mem_rW     <= mem_rW_nx;
            mem_ad_oe  <= mem_ad_oe_nx;
            mem_ad_out <= mem_ad_out_nx;
            rdata      <= rdata_nx;
        end
    end

endmodule
